cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3, number of completing functional units (ALU=0, MUL=1, LSU=2).
REQ-002 Parameter TAG_W, default 6, physical register tag width (64-entry PRF).
REQ-003 Parameter DATA_W, default 32, result data width.
REQ-004 Port clk  input  1  single clock; all state updates on posedge clk.
REQ-005 Port rst  input  1  reset, asynchronous, active-low.
REQ-006 Port flush  input  1  pipeline flush: kill all grants this cycle and clear the CDB output stage.
REQ-007 Port req_valid  input  NUM_REQ  per-unit completion request.
REQ-008 Port req_tag  input  NUM_REQ*TAG_W  per-unit destination physical tag, unit i at bits [i*TAG_W +: TAG_W].
REQ-009 Port req_data  input  NUM_REQ*DATA_W  per-unit result value, unit i at bits [i*DATA_W +: DATA_W].
REQ-010 Port req_regdest  input  NUM_REQ  per-unit flag: 1 if the instruction writes a register.
REQ-011 Port req_ready  output  NUM_REQ  one-hot grant; handshake completes when req_valid[i] & req_ready[i].
REQ-012 Port cdb_valid  output  1  CDB broadcast valid.
REQ-013 Port cdb_tag  output  TAG_W  broadcast tag; drives PRF write address p_rd.
REQ-014 Port cdb_data  output  DATA_W  broadcast value; drives PRF wr_data_in.
REQ-015 Port cdb_regdest  output  1  PRF write enable; drives RegDest_compl.

Function
REQ-016 req_ready SHALL be combinational, at most one bit set, set only for a unit with req_valid=1.
REQ-017 req_ready SHALL be all-zero while flush=1 or rst=0.
REQ-018 Selection SHALL be round-robin: search begins at pointer ptr and wraps from NUM_REQ-1 to 0.
REQ-019 After a grant to unit w, ptr SHALL become (w+1) mod NUM_REQ on the next posedge; without a grant ptr holds.
REQ-020 On a posedge with a grant, cdb_valid SHALL be 1 and cdb_tag/cdb_data SHALL take the winner's tag/data (latency exactly 1 cycle from handshake).
REQ-021 cdb_regdest SHALL equal the winner's req_regdest when cdb_valid=1, and 0 otherwise.
REQ-022 On a posedge with no grant, cdb_valid and cdb_regdest SHALL be 0; cdb_tag and cdb_data hold their previous values.
REQ-023 A request with req_regdest=0 SHALL still be arbitrated and broadcast, with cdb_regdest=0.
REQ-024 A unit holding req_valid=1 SHALL be granted within NUM_REQ consecutive cycles when flush stays 0.
REQ-025 The arbiter SHALL NOT buffer ungranted requests; a requester holds valid, tag, data and regdest stable until granted.
REQ-026 On flush=1, the next posedge SHALL clear cdb_valid and cdb_regdest; ptr holds; a broadcast already in the output stage at that edge is discarded.
REQ-027 Tag value 0 SHALL receive no special treatment.

Reset
REQ-028 Asserting rst SHALL immediately clear ptr, cdb_valid, cdb_regdest, cdb_tag and cdb_data to 0, independent of clk.
REQ-029 The first grant SHALL occur on the first posedge after rst deasserts, with unit 0 highest priority.

Structure
REQ-030 Shared package cdb_pkg SHALL hold TAG_W, DATA_W, NUM_REQ defaults and the unit-index constants ALU/MUL/LSU.
REQ-031 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: request vector, ptr; output: one-hot grant).
REQ-032 The output stage and ptr SHALL be the only state in cdb_arbiter.

Verification
REQ-033 Reset, then ALU only, valid with tag=4, data=32'hDEADBEEF, regdest=1 -> req_ready=3'b001; next cycle cdb_valid=1, cdb_tag=4, cdb_data=DEADBEEF, cdb_regdest=1.
REQ-034 All three units held valid for 6 cycles -> grant order ALU, MUL, LSU, ALU, MUL, LSU; each unit granted exactly twice.
REQ-035 MUL only, valid with regdest=0, tag=2, data=32'hABABABAB -> cdb_valid=1, cdb_regdest=0, cdb_tag=2.
REQ-036 All units valid and flush=1 for one cycle -> req_ready=0 that cycle; next cycle cdb_valid=0; ptr unchanged, so the next grant goes to the same unit as it would have without the flush.
REQ-037 rst driven low mid-stream, between clock edges, while cdb_valid=1 -> all outputs are 0 before the next posedge; after release, the first grant goes to ALU.
REQ-038 Random valid patterns for 10k cycles -> at most one grant per cycle, no requester waits more than 3 cycles, and each CDB value matches its granted request one cycle later.

Source files
------------

// File: rtl/cdb_pkg.sv
// Shared constants for the common-data-bus arbiter: default widths and
// the completing functional-unit indices.
package cdb_pkg;

    localparam int NUM_REQ_DEF = 3;
    localparam int TAG_W_DEF   = 6;
    localparam int DATA_W_DEF  = 32;

    typedef enum logic [1:0] {
        ALU = 2'd0,
        MUL = 2'd1,
        LSU = 2'd2
    } unit_e;

    // A single requester still needs a 1-bit pointer so vectors stay legal.
    function automatic int ptrWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: scans from ptr_i upward, wrapping at
// NUM_REQ-1, and returns a one-hot grant for the first active request.
module rr_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int PTR_W   = ptrWidth(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    logic             found;

    // The extra sum bit holds ptr+k before the single wrap subtraction.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr_i} + (PTR_W + 1)'(k);
            if (sum >= (PTR_W + 1)'(NUM_REQ)) begin
                sum = sum - (PTR_W + 1)'(NUM_REQ);
            end
            idx = sum[PTR_W-1:0];
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: grants one completing unit per cycle in
// round-robin order and registers the winner's result onto the CDB.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int TAG_W   = TAG_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_regdest,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_data,
    output logic                      cdb_regdest
);

    localparam int PTR_W = ptrWidth(NUM_REQ);

    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               cdbValid_q, cdbValid_d;
    logic               cdbRegdest_q, cdbRegdest_d;
    logic [TAG_W-1:0]   cdbTag_q, cdbTag_d;
    logic [DATA_W-1:0]  cdbData_q, cdbData_d;

    logic [NUM_REQ-1:0] arbGnt;
    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   winIdx;
    logic [TAG_W-1:0]   winTag;
    logic [DATA_W-1:0]  winData;
    logic               winRegdest;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (arbGnt)
    );

    // Gating here keeps a flush or a held reset from completing any handshake.
    always_comb begin
        grant = (flush || !rst) ? '0 : arbGnt;
    end

    assign req_ready = grant;

    always_comb begin
        winIdx     = '0;
        winTag     = '0;
        winData    = '0;
        winRegdest = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                winIdx     = PTR_W'(i);
                winTag     = req_tag[i*TAG_W +: TAG_W];
                winData    = req_data[i*DATA_W +: DATA_W];
                winRegdest = req_regdest[i];
            end
        end
    end

    // Tag and data hold when idle; only valid and the write enable drop.
    always_comb begin
        ptr_d        = ptr_q;
        cdbValid_d   = 1'b0;
        cdbRegdest_d = 1'b0;
        cdbTag_d     = cdbTag_q;
        cdbData_d    = cdbData_q;
        if (|grant) begin
            ptr_d        = (winIdx == PTR_W'(NUM_REQ - 1)) ? '0 : winIdx + PTR_W'(1);
            cdbValid_d   = 1'b1;
            cdbRegdest_d = winRegdest;
            cdbTag_d     = winTag;
            cdbData_d    = winData;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q        <= '0;
            cdbValid_q   <= 1'b0;
            cdbRegdest_q <= 1'b0;
            cdbTag_q     <= '0;
            cdbData_q    <= '0;
        end else begin
            ptr_q        <= ptr_d;
            cdbValid_q   <= cdbValid_d;
            cdbRegdest_q <= cdbRegdest_d;
            cdbTag_q     <= cdbTag_d;
            cdbData_q    <= cdbData_d;
        end
    end

    assign cdb_valid   = cdbValid_q;
    assign cdb_regdest = cdbRegdest_q;
    assign cdb_tag     = cdbTag_q;
    assign cdb_data    = cdbData_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios, a vector table, and a long
// randomized run against a round-robin reference model.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int N  = 3;
    localparam int TW = 6;
    localparam int DW = 32;

    localparam logic [N*TW-1:0] TBL_TAGS = {6'd12, 6'd11, 6'd10};
    localparam logic [N*DW-1:0] TBL_DATA = {32'h1000_000C, 32'h1000_000B, 32'h1000_000A};

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           flush = 1'b0;
    logic [N-1:0]   reqValid = '0;
    logic [N*TW-1:0] reqTag = '0;
    logic [N*DW-1:0] reqData = '0;
    logic [N-1:0]   reqRegdest = '0;
    logic [N-1:0]   reqReady;
    logic           cdbValid;
    logic [TW-1:0]  cdbTag;
    logic [DW-1:0]  cdbData;
    logic           cdbRegdest;

    int compared   = 0;
    int mismatched = 0;

    cdb_arbiter #(
        .NUM_REQ (N),
        .TAG_W   (TW),
        .DATA_W  (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .req_valid   (reqValid),
        .req_tag     (reqTag),
        .req_data    (reqData),
        .req_regdest (reqRegdest),
        .req_ready   (reqReady),
        .cdb_valid   (cdbValid),
        .cdb_tag     (cdbTag),
        .cdb_data    (cdbData),
        .cdb_regdest (cdbRegdest)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  valid;
        logic [N-1:0]  regdest;
        logic          flush;
        logic [N-1:0]  expReady;
        logic          expValid;
        logic          expRegdest;
        logic [TW-1:0] expTag;
    } vec_t;

    vec_t vecs[17];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] v, input logic [N-1:0] rd,
                                 input logic [N*TW-1:0] t, input logic [N*DW-1:0] d,
                                 input logic f);
        reqValid   = v;
        reqRegdest = rd;
        reqTag     = t;
        reqData    = d;
        flush      = f;
    endtask

    // Called just after a posedge: drive, check ready mid-cycle, then the CDB after the edge.
    task automatic doCycle(input string name, input logic [N-1:0] v, input logic [N-1:0] rd,
                           input logic [N*TW-1:0] t, input logic [N*DW-1:0] d, input logic f,
                           input logic [N-1:0] eReady, input logic eValid, input logic eRegdest,
                           input logic [TW-1:0] eTag, input logic [DW-1:0] eData);
        applyStimulus(v, rd, t, d, f);
        #2;
        checkOutput({name, " ready"}, 64'(reqReady), 64'(eReady));
        @(posedge clk);
        #1;
        checkOutput({name, " cdb_valid"}, 64'(cdbValid), 64'(eValid));
        checkOutput({name, " cdb_regdest"}, 64'(cdbRegdest), 64'(eRegdest));
        checkOutput({name, " cdb_tag"}, 64'(cdbTag), 64'(eTag));
        checkOutput({name, " cdb_data"}, 64'(cdbData), 64'(eData));
    endtask

    logic          pending[N];
    logic [TW-1:0] pTag[N];
    logic [DW-1:0] pData[N];
    logic          pReg[N];
    int            waitCycles[N];

    initial begin
        int            modelPtr;
        int            winner;
        logic [N-1:0]  vVec, rdVec, eReady;
        logic [N*TW-1:0] tVec;
        logic [N*DW-1:0] dVec;
        logic          eValid, eReg;
        logic [TW-1:0] holdTag;
        logic [DW-1:0] holdData;

        vecs[0]  = '{3'b111, 3'b111, 1'b0, 3'b001, 1'b1, 1'b1, 6'd10};
        vecs[1]  = '{3'b111, 3'b111, 1'b0, 3'b010, 1'b1, 1'b1, 6'd11};
        vecs[2]  = '{3'b111, 3'b111, 1'b0, 3'b100, 1'b1, 1'b1, 6'd12};
        vecs[3]  = '{3'b111, 3'b111, 1'b0, 3'b001, 1'b1, 1'b1, 6'd10};
        vecs[4]  = '{3'b111, 3'b111, 1'b0, 3'b010, 1'b1, 1'b1, 6'd11};
        vecs[5]  = '{3'b111, 3'b111, 1'b0, 3'b100, 1'b1, 1'b1, 6'd12};
        vecs[6]  = '{3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 6'd12};
        vecs[7]  = '{3'b111, 3'b111, 1'b1, 3'b000, 1'b0, 1'b0, 6'd12};
        vecs[8]  = '{3'b111, 3'b111, 1'b0, 3'b001, 1'b1, 1'b1, 6'd10};
        vecs[9]  = '{3'b111, 3'b111, 1'b1, 3'b000, 1'b0, 1'b0, 6'd10};
        vecs[10] = '{3'b111, 3'b111, 1'b0, 3'b010, 1'b1, 1'b1, 6'd11};
        vecs[11] = '{3'b101, 3'b001, 1'b0, 3'b100, 1'b1, 1'b0, 6'd12};
        vecs[12] = '{3'b110, 3'b110, 1'b0, 3'b010, 1'b1, 1'b1, 6'd11};
        vecs[13] = '{3'b011, 3'b011, 1'b0, 3'b001, 1'b1, 1'b1, 6'd10};
        vecs[14] = '{3'b100, 3'b000, 1'b0, 3'b100, 1'b1, 1'b0, 6'd12};
        vecs[15] = '{3'b111, 3'b010, 1'b1, 3'b000, 1'b0, 1'b0, 6'd12};
        vecs[16] = '{3'b111, 3'b111, 1'b0, 3'b001, 1'b1, 1'b1, 6'd10};

        // Reset state with requests already raised.
        applyStimulus(3'b111, 3'b111, TBL_TAGS, TBL_DATA, 1'b0);
        #2;
        checkOutput("reset ready", 64'(reqReady), 64'(0));
        checkOutput("reset cdb_valid", 64'(cdbValid), 64'(0));
        checkOutput("reset cdb_tag", 64'(cdbTag), 64'(0));
        checkOutput("reset cdb_data", 64'(cdbData), 64'(0));
        checkOutput("reset cdb_regdest", 64'(cdbRegdest), 64'(0));
        @(posedge clk);
        #1;
        checkOutput("reset hold cdb_valid", 64'(cdbValid), 64'(0));
        #2;
        rst = 1'b1;

        doCycle("alu only", 3'b001, 3'b001, {6'd0, 6'd0, 6'd4},
                {32'd0, 32'd0, 32'hDEADBEEF}, 1'b0, 3'b001, 1'b1, 1'b1, 6'd4, 32'hDEADBEEF);
        doCycle("mul nodest", 3'b010, 3'b000, {6'd0, 6'd2, 6'd0},
                {32'd0, 32'hABABABAB, 32'd0}, 1'b0, 3'b010, 1'b1, 1'b0, 6'd2, 32'hABABABAB);
        doCycle("lsu tag0", 3'b100, 3'b100, {6'd0, 6'd0, 6'd0},
                {32'h5, 32'd0, 32'd0}, 1'b0, 3'b100, 1'b1, 1'b1, 6'd0, 32'h5);

        for (int i = 0; i < 17; i++) begin
            doCycle($sformatf("vec%0d", i), vecs[i].valid, vecs[i].regdest, TBL_TAGS, TBL_DATA,
                    vecs[i].flush, vecs[i].expReady, vecs[i].expValid, vecs[i].expRegdest,
                    vecs[i].expTag, 32'h1000_0000 | DW'(vecs[i].expTag));
        end

        // Reset mid-cycle while a broadcast is live; pointer must restart at ALU.
        doCycle("pre-reset", 3'b111, 3'b111, TBL_TAGS, TBL_DATA, 1'b0,
                3'b010, 1'b1, 1'b1, 6'd11, 32'h1000_000B);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("async rst ready", 64'(reqReady), 64'(0));
        checkOutput("async rst cdb_valid", 64'(cdbValid), 64'(0));
        checkOutput("async rst cdb_tag", 64'(cdbTag), 64'(0));
        checkOutput("async rst cdb_data", 64'(cdbData), 64'(0));
        checkOutput("async rst cdb_regdest", 64'(cdbRegdest), 64'(0));
        #1;
        rst = 1'b1;
        doCycle("post-reset", 3'b111, 3'b111, TBL_TAGS, TBL_DATA, 1'b0,
                3'b001, 1'b1, 1'b1, 6'd10, 32'h1000_000A);

        // Randomized phase: requesters hold their request until granted.
        modelPtr = 1;
        holdTag  = 6'd10;
        holdData = 32'h1000_000A;
        for (int u = 0; u < N; u++) begin
            pending[u]    = 1'b0;
            pTag[u]       = '0;
            pData[u]      = '0;
            pReg[u]       = 1'b0;
            waitCycles[u] = 0;
        end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int u = 0; u < N; u++) begin
                if (!pending[u] && ($urandom_range(1, 0) == 1)) begin
                    pending[u]    = 1'b1;
                    pTag[u]       = TW'($urandom);
                    pData[u]      = $urandom;
                    pReg[u]       = 1'($urandom_range(1, 0));
                    waitCycles[u] = 0;
                end
                vVec[u]              = pending[u];
                rdVec[u]             = pending[u] ? pReg[u] : 1'b0;
                tVec[u*TW +: TW]     = pTag[u];
                dVec[u*DW +: DW]     = pData[u];
            end
            winner = -1;
            for (int k = 0; k < N; k++) begin
                int u;
                u = (modelPtr + k) % N;
                if (winner < 0 && pending[u]) winner = u;
            end
            eReady = (winner >= 0) ? N'(1 << winner) : '0;
            applyStimulus(vVec, rdVec, tVec, dVec, 1'b0);
            #2;
            checkOutput("rand ready", 64'(reqReady), 64'(eReady));
            checkOutput("rand onehot", 64'($countones(reqReady) <= 1), 64'(1));
            for (int u = 0; u < N; u++) begin
                if (pending[u]) waitCycles[u]++;
            end
            if (winner >= 0) begin
                checkOutput("rand wait bound", 64'(waitCycles[winner] <= N), 64'(1));
                eValid   = 1'b1;
                eReg     = pReg[winner];
                holdTag  = pTag[winner];
                holdData = pData[winner];
                pending[winner] = 1'b0;
                modelPtr = (winner + 1) % N;
            end else begin
                eValid = 1'b0;
                eReg   = 1'b0;
            end
            @(posedge clk);
            #1;
            checkOutput("rand cdb_valid", 64'(cdbValid), 64'(eValid));
            checkOutput("rand cdb_regdest", 64'(cdbRegdest), 64'(eReg));
            checkOutput("rand cdb_tag", 64'(cdbTag), 64'(holdTag));
            checkOutput("rand cdb_data", 64'(cdbData), 64'(holdData));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
